// File: rtl/button_event_pkg.sv
// Shared types for the button gesture decoder: FSM states, event codes and
// a small elaboration-time helper.
package button_event_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned EVENT_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    PRESS  = 3'd1,
    HELD   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_e;

  // Event codes are stable for downstream logging.
  typedef enum logic [EVENT_W-1:0] {
    SHORT  = 2'd0,
    DOUBLE = 2'd1,
    LONG   = 2'd2,
    REPEAT = 2'd3
  } event_e;

  typedef struct packed {
    logic   vld;
    event_e code;
  } event_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/gesture_timer.sv
// Saturating gesture interval counter with registered terminal-count flags
// for the long-press, double-click and repeat thresholds.
module gesture_timer #(
  parameter int unsigned CNT_W        = 29,
  parameter int unsigned LONG_TICKS   = 200_000_000,
  parameter int unsigned DOUBLE_TICKS = 40_000_000,
  parameter int unsigned REPEAT_TICKS = 20_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic preload_i,
  input  logic en_i,
  output logic long_hit_o,
  output logic double_hit_o,
  output logic repeat_hit_o
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             long_hit_q, double_hit_q, repeat_hit_q;

  // Clear wins over preload; counting stops at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (preload_i) begin
      cnt_d = CNT_W'(1);
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Flags are computed from the next count so they line up with cnt_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      long_hit_q   <= 1'b0;
      double_hit_q <= 1'b0;
      repeat_hit_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      long_hit_q   <= (cnt_d == LONG_LAST);
      double_hit_q <= (cnt_d == DOUBLE_LAST);
      repeat_hit_q <= (cnt_d == REPEAT_LAST);
    end
  end

  assign long_hit_o   = long_hit_q;
  assign double_hit_o = double_hit_q;
  assign repeat_hit_o = repeat_hit_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into short press, double click,
// long press and auto-repeat, emitting registered one-cycle event pulses.
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = 200_000_000,
  parameter int unsigned DOUBLE_TICKS = 40_000_000,
  parameter int unsigned REPEAT_TICKS = 20_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic debounced,
  input  logic p_edge,
  input  logic n_edge,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_press,
  output logic busy
);

  localparam int unsigned CNT_W =
    $clog2(max3(LONG_TICKS, DOUBLE_TICKS, REPEAT_TICKS)) + 1;

  if ((LONG_TICKS < 2) || (DOUBLE_TICKS < 2) || (REPEAT_TICKS < 2)) begin : g_param_check
    $error("button_event_decoder: tick parameters must be >= 2");
  end

  state_e state_q, state_d;
  event_t evt_c;
  logic   both_c, press_c, release_c;
  logic   long_hit, double_hit, repeat_hit;
  logic   cnt_clear_c, cnt_preload_c, cnt_en_c;
  logic   short_q, double_q, long_q, repeat_q, busy_q;

  // Simultaneous edges are contradictory and ignored; a low level while
  // pressed covers an n_edge pulse that went missing upstream.
  assign both_c    = p_edge & n_edge;
  assign press_c   = p_edge & ~n_edge;
  assign release_c = ~both_c & (n_edge | ~debounced);

  gesture_timer #(
    .CNT_W       (CNT_W),
    .LONG_TICKS  (LONG_TICKS),
    .DOUBLE_TICKS(DOUBLE_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) u_timer (
    .clk         (clk),
    .rst_n       (reset_n),
    .clear_i     (cnt_clear_c),
    .preload_i   (cnt_preload_c),
    .en_i        (cnt_en_c),
    .long_hit_o  (long_hit),
    .double_hit_o(double_hit),
    .repeat_hit_o(repeat_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Release has priority over the long-press threshold; a second press has
  // priority over the double-click timeout.
  always_comb begin
    state_d = state_q;
    evt_c   = '0;
    case (state_q)
      IDLE: begin
        if (press_c) state_d = PRESS;
      end
      PRESS: begin
        if (release_c) begin
          state_d = GAP;
        end else if (long_hit) begin
          state_d    = HELD;
          evt_c.vld  = 1'b1;
          evt_c.code = LONG;
        end
      end
      HELD: begin
        if (release_c) begin
          state_d = IDLE;
        end else if (repeat_hit) begin
          evt_c.vld  = 1'b1;
          evt_c.code = REPEAT;
        end
      end
      GAP: begin
        if (press_c) begin
          state_d    = PRESS2;
          evt_c.vld  = 1'b1;
          evt_c.code = DOUBLE;
        end else if (double_hit) begin
          state_d    = IDLE;
          evt_c.vld  = 1'b1;
          evt_c.code = SHORT;
        end
      end
      PRESS2: begin
        if (release_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The count is measured from the cycle of the triggering event: an edge
  // precedes its state by one cycle (preload 1), a long/repeat pulse
  // coincides with the cycle the count restarts (clear to 0).
  always_comb begin
    cnt_clear_c   = 1'b0;
    cnt_preload_c = 1'b0;
    cnt_en_c      = 1'b0;
    if ((state_d == IDLE) ||
        ((state_d == HELD) && ((state_q != HELD) || evt_c.vld))) begin
      cnt_clear_c = 1'b1;
    end else if (state_d != state_q) begin
      cnt_preload_c = 1'b1;
    end else begin
      cnt_en_c = (state_q == PRESS) || (state_q == HELD) || (state_q == GAP);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      short_q  <= evt_c.vld && (evt_c.code == SHORT);
      double_q <= evt_c.vld && (evt_c.code == DOUBLE);
      long_q   <= evt_c.vld && (evt_c.code == LONG);
      repeat_q <= evt_c.vld && (evt_c.code == REPEAT);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign short_press  = short_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign repeat_press = repeat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with a timestamp-based gesture
// model checked every cycle, plus literal latency/count expectations.
module tb_button_event_decoder;

  localparam int unsigned LT = 8;
  localparam int unsigned DT = 5;
  localparam int unsigned RT = 4;

  localparam int PH_IDLE   = 0;
  localparam int PH_FIRST  = 1;
  localparam int PH_HOLD   = 2;
  localparam int PH_WAIT   = 3;
  localparam int PH_SECOND = 4;

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic debounced = 1'b0;
  logic p_edge    = 1'b0;
  logic n_edge    = 1'b0;
  logic short_press, double_click, long_press, repeat_press, busy;

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_TICKS  (LT),
    .DOUBLE_TICKS(DT),
    .REPEAT_TICKS(RT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .debounced   (debounced),
    .p_edge      (p_edge),
    .n_edge      (n_edge),
    .short_press (short_press),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_press(repeat_press),
    .busy        (busy)
  );

  // ex = {short, double, long, repeat, busy} expected for the next cycle
  typedef struct packed {
    int         ph;
    int         t0;
    logic [4:0] ex;
  } mdl_t;

  mdl_t m;
  int   tcyc;
  int   total = 0;
  int   bad   = 0;
  int   n_short = 0, n_double = 0, n_long = 0, n_repeat = 0;
  int   at_short = 0, at_double = 0, at_long = 0, at_repeat = 0;
  int   s_short, s_double, s_long, s_repeat;
  int   tp, tn;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, tcyc);
    end
  endtask

  // Pulse times are derived from the cycle of the triggering edge (t0).
  function automatic mdl_t model_step(input mdl_t s, input int c,
                                      input logic p, input logic n, input logic d);
    mdl_t r;
    logic both, prs, rel;
    r    = s;
    r.ex = '0;
    both = p & n;
    prs  = p & ~n;
    rel  = ~both & (n | ~d);
    case (s.ph)
      PH_IDLE:   if (prs) begin r.ph = PH_FIRST; r.t0 = c; end
      PH_FIRST: begin
        if (rel) begin
          r.ph = PH_WAIT; r.t0 = c;
        end else if (c - s.t0 == int'(LT) - 1) begin
          r.ph = PH_HOLD; r.t0 = c + 1; r.ex[2] = 1'b1;
        end
      end
      PH_HOLD: begin
        if (rel) r.ph = PH_IDLE;
        else if (((c + 1 - s.t0) % int'(RT)) == 0) r.ex[1] = 1'b1;
      end
      PH_WAIT: begin
        if (prs) begin
          r.ph = PH_SECOND; r.ex[3] = 1'b1;
        end else if (c - s.t0 == int'(DT) - 1) begin
          r.ph = PH_IDLE; r.ex[4] = 1'b1;
        end
      end
      PH_SECOND: if (rel) r.ph = PH_IDLE;
      default:   r.ph = PH_IDLE;
    endcase
    r.ex[0] = (r.ph != PH_IDLE);
    return r;
  endfunction

  initial begin
    m    = '0;
    tcyc = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m = '0;
      end else begin
        m = model_step(m, tcyc, p_edge, n_edge, debounced);
        tcyc++;
      end
    end
  end

  initial begin
    logic [4:0] pulses;
    forever begin
      @(negedge clk);
      pulses = {short_press, double_click, long_press, repeat_press, busy};
      chk("outputs_vs_model", int'(pulses), int'(m.ex));
      chk("one_pulse_max", int'($countones(pulses[4:1]) <= 1), 1);
      if (short_press)  begin n_short++;  at_short  = tcyc; end
      if (double_click) begin n_double++; at_double = tcyc; end
      if (long_press)   begin n_long++;   at_long   = tcyc; end
      if (repeat_press) begin n_repeat++; at_repeat = tcyc; end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive(input logic d, input logic p, input logic n);
    debounced = d;
    p_edge    = p;
    n_edge    = n;
    @(posedge clk);
    #1;
  endtask

  task automatic press_for(input int cycles);
    tp = tcyc;
    drive(1'b1, 1'b1, 1'b0);
    repeat (cycles - 1) drive(1'b1, 1'b0, 1'b0);
  endtask

  task automatic release_edge();
    tn = tcyc;
    drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int k);
    repeat (k) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic snap();
    s_short  = n_short;
    s_double = n_double;
    s_long   = n_long;
    s_repeat = n_repeat;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({short_press, double_click, long_press, repeat_press, busy}), 0);
    reset_n = 1'b1;
    idle(2);

    // 1: short press
    snap();
    press_for(3);
    release_edge();
    idle(10);
    chk("t1_short_cnt", n_short - s_short, 1);
    chk("t1_short_lat", at_short - tn, 5);
    chk("t1_other_cnt", (n_double - s_double) + (n_long - s_long) + (n_repeat - s_repeat), 0);

    // 2: double click
    snap();
    press_for(3);
    release_edge();
    idle(1);
    press_for(3);
    release_edge();
    idle(10);
    chk("t2_double_cnt", n_double - s_double, 1);
    chk("t2_double_lat", at_double - tp, 1);
    chk("t2_short_cnt", n_short - s_short, 0);

    // 3: long press with auto-repeat
    snap();
    press_for(20);
    chk("t3_busy_held", int'(busy), 1);
    release_edge();
    chk("t3_busy_after", int'(busy), 0);
    idle(3);
    chk("t3_long_cnt", n_long - s_long, 1);
    chk("t3_long_lat", at_long - tp, 8);
    chk("t3_repeat_cnt", n_repeat - s_repeat, 3);
    chk("t3_last_repeat_lat", at_repeat - tp, 20);
    chk("t3_short_cnt", n_short - s_short, 0);

    // 4a: release on the long-press threshold cycle
    snap();
    press_for(7);
    release_edge();
    idle(10);
    chk("t4a_long_cnt", n_long - s_long, 0);
    chk("t4a_short_cnt", n_short - s_short, 1);
    chk("t4a_short_lat", at_short - tn, 5);

    // 4b: second press on the double-click timeout cycle
    snap();
    press_for(3);
    release_edge();
    idle(3);
    press_for(3);
    release_edge();
    idle(10);
    chk("t4b_double_cnt", n_double - s_double, 1);
    chk("t4b_double_lat", at_double - tp, 1);
    chk("t4b_short_cnt", n_short - s_short, 0);

    // 5: asynchronous reset while held
    press_for(12);
    chk("t5_repeat_before_reset", int'(repeat_press), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_outputs_in_reset", int'({short_press, double_click, long_press, repeat_press, busy}), 0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    snap();
    repeat (3) drive(1'b1, 1'b0, 1'b0);
    release_edge();
    idle(10);
    chk("t5_pulses_after_reset", (n_short - s_short) + (n_double - s_double) +
                                 (n_long - s_long) + (n_repeat - s_repeat), 0);
    chk("t5_busy", int'(busy), 0);

    // 6: simultaneous p_edge and n_edge while pressed
    snap();
    press_for(3);
    drive(1'b1, 1'b1, 1'b1);
    chk("t6_busy_after_illegal", int'(busy), 1);
    drive(1'b1, 1'b0, 1'b0);
    release_edge();
    idle(10);
    chk("t6_short_cnt", n_short - s_short, 1);
    chk("t6_short_lat", at_short - tn, 5);
    chk("t6_other_cnt", (n_double - s_double) + (n_long - s_long) + (n_repeat - s_repeat), 0);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
